line_fill_ctrl: RTL and testbench
=================================

LINE_FILL_CTRL -- requirements
Module: line_fill_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): H_ACTIVE, 800, visible pixels per line; V_ACTIVE, 600, visible lines; HCOUNT_MAX, 1055, last hcount of a line; VCOUNT_MAX, 627, last vcount of a frame; MAX_OUT, 4, maximum outstanding pixel requests.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports (name direction width meaning): clk in 1 system clock; rst in 1 synchronous active-high reset.
REQ-003 hcount in 11 current horizontal count; vcount in 11 current vertical count.
REQ-004 req_valid out 1 pixel-read request; req_ready in 1 source accepts request; req_x out 11 requested pixel column; req_y out 11 requested pixel row.
REQ-005 rsp_valid in 1 pixel returned, in request order; rsp_rgb in 12 returned pixel colour.
REQ-006 wr_en out 1 line-buffer write strobe; wr_bank out 1 bank written; wr_addr out 11 write column; wr_data out 12 write colour.
REQ-007 rd_bank out 1 bank the display reads; fill_done out 1 one-cycle pulse when a line fill completes; underrun out 1 one-cycle pulse when a swap finds a fill incomplete.

Function
REQ-008 The block SHALL sequence a two-bank line buffer: the display reads rd_bank, the fill writes wr_bank = ~rd_bank at all times.
REQ-009 Swap event = (hcount == HCOUNT_MAX); on the cycle after a swap event rd_bank SHALL have toggled.
REQ-010 On a swap event the fill target SHALL be set to fill_y = (vcount + 2) wrapped modulo (VCOUNT_MAX + 1).
REQ-011 States SHALL be IDLE, REQ, WAIT, DONE and DRAIN; reset enters IDLE.
REQ-012 IDLE/DONE -> REQ on a swap event when fill_y < V_ACTIVE; -> DONE (no requests, no fill_done) when fill_y >= V_ACTIVE.
REQ-013 In REQ, req_valid SHALL be high while issued < H_ACTIVE and outstanding < MAX_OUT, with req_x = issued and req_y = fill_y.
REQ-014 req_valid, req_x and req_y SHALL remain stable until req_valid && req_ready; issued increments by one per handshake.
REQ-015 REQ -> WAIT when issued reaches H_ACTIVE; WAIT -> DONE when received reaches H_ACTIVE, with fill_done pulsed on that transition.
REQ-016 outstanding SHALL increment per accepted request, decrement per rsp_valid, and stay unchanged when both occur in the same cycle; range 0..MAX_OUT.
REQ-017 Each rsp_valid in REQ/WAIT SHALL produce, one cycle later, wr_en=1, wr_addr=received, wr_data=rsp_rgb, wr_bank=current fill bank; received then increments.
REQ-018 rsp_valid while outstanding == 0 SHALL be ignored: no write, and no counter changes.
REQ-019 A swap event in REQ or WAIT SHALL pulse underrun, toggle rd_bank, stop requests immediately (req_valid low from next cycle) and enter DRAIN if outstanding > 0, else REQ/DONE per REQ-012.
REQ-020 In DRAIN, responses SHALL decrement outstanding without writing; when outstanding reaches 0 the state SHALL move to REQ or DONE per REQ-012 using the latest fill_y, with issued and received cleared.
REQ-021 A swap event in DRAIN SHALL pulse underrun, toggle rd_bank, update fill_y and remain in DRAIN.
REQ-022 issued and received SHALL clear on every entry to REQ.

Reset
REQ-023 While rst is high at a clock edge: state=IDLE, rd_bank=0, req_valid=0, wr_en=0, fill_done=0, underrun=0; req_x, req_y, wr_addr, wr_data, issued, received, outstanding and fill_y SHALL all be 0.
REQ-024 Reset asserted during REQ/WAIT/DRAIN SHALL abandon the fill with no underrun pulse; responses arriving after reset SHALL be ignored per REQ-018.

Verification
REQ-025 Source with ready=1 and 2-cycle fixed latency; swap at vcount=10 -> fill_y=12, 800 writes to addr 0..799 on bank 1, fill_done once, no underrun.
REQ-026 Source with ready=1 and no responses -> exactly 4 requests (x=0..3), req_valid then low; at the next swap underrun=1 for 1 cycle, rd_bank toggles and state enters DRAIN.
REQ-027 Swap at vcount=598 -> fill_y=600 -> DONE, no requests, no fill_done; swap at vcount=626 -> fill_y=0 and requests are issued with req_y=0.
REQ-028 req_ready toggled randomly -> req_x is held while not ready, no duplicate or skipped x, and wr_addr is a monotonic 0..799.
REQ-029 Same-cycle request handshake and rsp_valid -> outstanding unchanged; stray rsp_valid in IDLE -> no wr_en.
REQ-030 Reset pulsed mid-REQ -> all outputs 0 on the next cycle; late responses produce no write; the next swap yields a normal fill with rd_bank toggled to 1.

Source files
------------

// File: rtl/line_fill_ctrl_if.sv
// Pixel-fetch handshake and line-buffer write bus shared by the fill controller,
// the pixel source and the two-bank line buffer.
interface line_fill_ctrl_if;
  localparam int unsigned COORD_W = 11;
  localparam int unsigned RGB_W   = 12;

  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;
  logic               rsp_valid;
  logic [RGB_W-1:0]   rsp_rgb;
  logic               wr_en;
  logic               wr_bank;
  logic [COORD_W-1:0] wr_addr;
  logic [RGB_W-1:0]   wr_data;

  modport master (
    output req_valid, req_x, req_y, wr_en, wr_bank, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_rgb
  );

  modport slave (
    input  req_valid, req_x, req_y, wr_en, wr_bank, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_rgb
  );
endinterface

// File: rtl/line_fill_ctrl.sv
// Two-bank line-buffer fill sequencer: fetches the line two rows ahead of the
// display while the display scans the other bank, swapping banks every line.
module line_fill_ctrl #(
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned HCOUNT_MAX = 1055,
  parameter int unsigned VCOUNT_MAX = 627,
  parameter int unsigned MAX_OUT    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [10:0]             hcount,
  input  logic [10:0]             vcount,
  line_fill_ctrl_if.master        bus,
  output logic                    rd_bank,
  output logic                    fill_done,
  output logic                    underrun
);

  localparam int unsigned COORD_W = 11;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned CNT_W   = $clog2(H_ACTIVE + 1);
  localparam int unsigned OUT_W   = $clog2(MAX_OUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_e;

  state_e             state_q;
  logic               rd_bank_q;
  logic               wr_bank_q;
  logic               req_valid_q;
  logic [COORD_W-1:0] req_x_q;
  logic [COORD_W-1:0] req_y_q;
  logic               wr_en_q;
  logic [COORD_W-1:0] wr_addr_q;
  logic [RGB_W-1:0]   wr_data_q;
  logic               fill_done_q;
  logic               underrun_q;
  logic [CNT_W-1:0]   issued_q;
  logic [CNT_W-1:0]   received_q;
  logic [OUT_W-1:0]   out_q;
  logic [COORD_W-1:0] fill_y_q;

  logic               swap;
  logic [COORD_W:0]   vsum;
  logic [COORD_W:0]   vwrap;
  logic [COORD_W-1:0] fill_y_d;
  logic               line_ok;
  logic               hs;
  logic               rsp_acc;
  logic               filling;
  logic               wr_fire;
  logic [OUT_W-1:0]   out_d;
  logic [CNT_W-1:0]   issued_inc;
  logic [CNT_W-1:0]   received_inc;
  logic [CNT_W-1:0]   issued_d;
  logic [CNT_W-1:0]   received_d;
  logic               restart;
  state_e             state_d;
  logic               underrun_d;
  logic               fill_done_d;
  logic               req_valid_d;

  // Swap detection, target-row wrap and counter bookkeeping
  always_comb begin
    swap     = (hcount == COORD_W'(HCOUNT_MAX));
    vsum     = (COORD_W+1)'(vcount) + (COORD_W+1)'(2);
    vwrap    = vsum;
    if (vsum > (COORD_W+1)'(VCOUNT_MAX)) begin
      vwrap = vsum - (COORD_W+1)'(VCOUNT_MAX + 1);
    end
    fill_y_d = swap ? COORD_W'(vwrap) : fill_y_q;
    line_ok  = (fill_y_d < COORD_W'(V_ACTIVE));

    hs       = req_valid_q & bus.req_ready;
    // A response with nothing outstanding is stray and leaves no trace
    rsp_acc  = bus.rsp_valid & (out_q != '0);
    filling  = (state_q == S_REQ) || (state_q == S_WAIT);
    wr_fire  = rsp_acc & filling & ~swap;

    out_d = out_q;
    if (hs && !rsp_acc) begin
      out_d = out_q + OUT_W'(1);
    end else if (!hs && rsp_acc) begin
      out_d = out_q - OUT_W'(1);
    end

    issued_inc   = issued_q + CNT_W'(hs);
    received_inc = received_q + CNT_W'(wr_fire);
  end

  // Next-state selection and one-cycle pulse generation
  always_comb begin
    state_d     = state_q;
    restart     = 1'b0;
    underrun_d  = 1'b0;
    fill_done_d = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (swap) begin
          restart = 1'b1;
        end
      end
      S_REQ, S_WAIT: begin
        if (swap) begin
          underrun_d = 1'b1;
          if (out_d != '0) begin
            state_d = S_DRAIN;
          end else begin
            restart = 1'b1;
          end
        end else if (received_inc == CNT_W'(H_ACTIVE)) begin
          state_d     = S_DONE;
          fill_done_d = 1'b1;
        end else if (issued_inc == CNT_W'(H_ACTIVE)) begin
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        underrun_d = swap;
        if (out_d == '0) begin
          restart = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d = line_ok ? S_REQ : S_DONE;
    end

    issued_d    = restart ? '0 : issued_inc;
    received_d  = restart ? '0 : received_inc;
    req_valid_d = (state_d == S_REQ) && (issued_d < CNT_W'(H_ACTIVE))
                  && (out_d < OUT_W'(MAX_OUT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_bank_q   <= 1'b0;
      wr_bank_q   <= 1'b1;
      req_valid_q <= 1'b0;
      req_x_q     <= '0;
      req_y_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fill_done_q <= 1'b0;
      underrun_q  <= 1'b0;
      issued_q    <= '0;
      received_q  <= '0;
      out_q       <= '0;
      fill_y_q    <= '0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      received_q  <= received_d;
      out_q       <= out_d;
      fill_y_q    <= fill_y_d;
      fill_done_q <= fill_done_d;
      underrun_q  <= underrun_d;
      req_valid_q <= req_valid_d;
      wr_en_q     <= wr_fire;

      if (swap) begin
        rd_bank_q <= ~rd_bank_q;
        wr_bank_q <= rd_bank_q;
      end

      // Address only moves on handshake, so it stays put while stalled
      if (state_d == S_REQ) begin
        req_x_q <= COORD_W'(issued_d);
        req_y_q <= fill_y_d;
      end

      if (wr_fire) begin
        wr_addr_q <= COORD_W'(received_q);
        wr_data_q <= bus.rsp_rgb;
      end
    end
  end

  assign bus.req_valid = req_valid_q;
  assign bus.req_x     = req_x_q;
  assign bus.req_y     = req_y_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_bank   = wr_bank_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign rd_bank       = rd_bank_q;
  assign fill_done     = fill_done_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Randomized bench for line_fill_ctrl: behavioural pixel source plus a
// transaction-level model of the fill sequence, checked every cycle.
module tb_line_fill_ctrl;
  localparam int unsigned H_ACTIVE   = 800;
  localparam int unsigned V_ACTIVE   = 600;
  localparam int unsigned HCOUNT_MAX = 1055;
  localparam int unsigned VCOUNT_MAX = 627;
  localparam int unsigned MAX_OUT    = 4;

  logic        clk;
  logic        rst;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        rd_bank;
  logic        fill_done;
  logic        underrun;

  line_fill_ctrl_if bus();

  line_fill_ctrl #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .HCOUNT_MAX(HCOUNT_MAX),
    .VCOUNT_MAX(VCOUNT_MAX), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .bus(bus),
    .rd_bank(rd_bank), .fill_done(fill_done), .underrun(underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Source environment
  longint     cyc = 0;
  longint     src_due[$];
  logic [11:0] src_rgb[$];
  int         lat = 2;
  bit         rsp_en = 1'b1;
  bit         stray = 1'b0;
  int         ready_mode = 0;

  // Model of the fill sequence: act 0 = no fill, 1 = fetching line, 2 = draining
  int          m_act = 0, m_iss = 0, m_rcv = 0, m_out = 0, m_fy = 0;
  bit          m_rb = 1'b0;
  bit          e_rv = 1'b0, e_we = 1'b0, e_fd = 1'b0, e_ur = 1'b0;
  int          e_rx = 0, e_ry = 0, e_wa = 0;
  logic [11:0] e_wd = '0;

  int obs_fd = 0, obs_ur = 0, obs_wr = 0, obs_wr_b1 = 0, obs_req = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] pix(input int x, input int y);
    return 12'((x * 5) + (y * 77) + 961);
  endfunction

  task automatic model_start();
    m_act = (m_fy < int'(V_ACTIVE)) ? 1 : 0;
    m_iss = 0;
    m_rcv = 0;
  endtask

  task automatic model_update(input bit sw, input int vc);
    bit hs;
    bit rok;
    hs   = e_rv && bus.req_ready;
    rok  = bus.rsp_valid && (m_out > 0);
    e_we = 1'b0;
    e_fd = 1'b0;
    e_ur = 1'b0;
    if (rst) begin
      m_act = 0; m_iss = 0; m_rcv = 0; m_out = 0; m_fy = 0; m_rb = 1'b0;
    end else begin
      m_out = m_out + (hs ? 1 : 0) - (rok ? 1 : 0);
      if (hs) m_iss++;
      if (sw) begin
        m_fy = (vc + 2) % int'(VCOUNT_MAX + 1);
        m_rb = !m_rb;
        if (m_act != 0) e_ur = 1'b1;
        if (m_act != 0 && m_out > 0) m_act = 2;
        else model_start();
      end else if (m_act == 1 && rok) begin
        e_we = 1'b1;
        e_wa = m_rcv;
        e_wd = bus.rsp_rgb;
        m_rcv++;
        if (m_rcv == int'(H_ACTIVE)) begin
          e_fd  = 1'b1;
          m_act = 0;
        end
      end else if (m_act == 2 && m_out == 0) begin
        model_start();
      end
    end
    e_rv = (m_act == 1) && (m_iss < int'(H_ACTIVE)) && (m_out < int'(MAX_OUT));
    e_rx = m_iss;
    e_ry = m_fy;
  endtask

  task automatic check_outputs();
    bit exp_wb;
    exp_wb = !m_rb;
    check_eq("rd_bank", 32'(rd_bank), 32'(m_rb));
    check_eq("wr_bank", 32'(bus.wr_bank), 32'(exp_wb));
    check_eq("req_valid", 32'(bus.req_valid), 32'(e_rv));
    if (e_rv) begin
      check_eq("req_x", 32'(bus.req_x), 32'(e_rx));
      check_eq("req_y", 32'(bus.req_y), 32'(e_ry));
    end
    check_eq("wr_en", 32'(bus.wr_en), 32'(e_we));
    if (e_we) begin
      check_eq("wr_addr", 32'(bus.wr_addr), 32'(e_wa));
      check_eq("wr_data", 32'(bus.wr_data), 32'(e_wd));
    end
    check_eq("fill_done", 32'(fill_done), 32'(e_fd));
    check_eq("underrun", 32'(underrun), 32'(e_ur));
    if (fill_done) obs_fd++;
    if (underrun) obs_ur++;
    if (bus.wr_en) begin
      obs_wr++;
      if (bus.wr_bank) obs_wr_b1++;
    end
  endtask

  // One clock: drive inputs, advance the model, clock, then check at negedge
  task automatic step(input bit sw, input int vc);
    bit          acc;
    logic [10:0] ax, ay;
    longint      tmp;
    hcount = sw ? 11'(HCOUNT_MAX) : 11'($urandom_range(HCOUNT_MAX - 1, 0));
    vcount = 11'(vc);
    case (ready_mode)
      0:       bus.req_ready = 1'b1;
      1:       bus.req_ready = 1'($urandom_range(1, 0));
      default: bus.req_ready = 1'b0;
    endcase
    if (rst) bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rgb   = 12'($urandom);
    if (stray) begin
      bus.rsp_valid = 1'b1;
    end else if (rsp_en && src_due.size() > 0 && src_due[0] <= cyc + 1) begin
      bus.rsp_valid = 1'b1;
      bus.rsp_rgb   = src_rgb.pop_front();
      tmp           = src_due.pop_front();
    end
    acc = bus.req_valid && bus.req_ready;
    ax  = bus.req_x;
    ay  = bus.req_y;
    model_update(sw, vc);
    @(posedge clk);
    cyc++;
    if (acc) begin
      src_due.push_back(cyc + longint'(lat));
      src_rgb.push_back(pix(int'(ax), int'(ay)));
      obs_req++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_until_fill(input int budget, input string tag);
    int start_fd;
    int n;
    start_fd = obs_fd;
    n = 0;
    while (obs_fd == start_fd && n < budget) begin
      step(1'b0, 0);
      n++;
    end
    check_eq(tag, 32'(obs_fd - start_fd), 32'd1);
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_req_x"}, 32'(bus.req_x), 32'd0);
    check_eq({tag, "_req_y"}, 32'(bus.req_y), 32'd0);
    check_eq({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    check_eq({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
  endtask

  task automatic clear_obs();
    obs_fd = 0; obs_ur = 0; obs_wr = 0; obs_wr_b1 = 0; obs_req = 0;
  endtask

  initial begin
    rst = 1'b1;
    hcount = '0;
    vcount = '0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rgb   = '0;
    @(negedge clk);
    step(1'b0, 0);
    step(1'b0, 0);
    reset_checks("rst");
    rst = 1'b0;

    // Stray responses while idle
    stray = 1'b1;
    repeat (3) step(1'b0, 5);
    stray = 1'b0;
    check_eq("stray_wr", 32'(obs_wr), 32'd0);

    // Target row beyond the active area: no fetch
    clear_obs();
    step(1'b1, 598);
    repeat (20) step(1'b0, 598);
    check_eq("blank_reqs", 32'(obs_req), 32'd0);
    check_eq("blank_done", 32'(obs_fd), 32'd0);

    // Full fill of row 12 with an always-ready, latency-2 source
    clear_obs();
    step(1'b1, 10);
    run_until_fill(2000, "fill_row12");
    repeat (5) step(1'b0, 10);
    check_eq("row12_writes", 32'(obs_wr), 32'(H_ACTIVE));
    check_eq("row12_bank1", 32'(obs_wr_b1), 32'(H_ACTIVE));
    check_eq("row12_done_cnt", 32'(obs_fd), 32'd1);
    check_eq("row12_underrun", 32'(obs_ur), 32'd0);

    // Row wrap to 0 with a randomly stalling source
    clear_obs();
    ready_mode = 1;
    lat = int'($urandom_range(3, 1));
    step(1'b1, 626);
    run_until_fill(6000, "fill_row0");
    check_eq("row0_writes", 32'(obs_wr), 32'(H_ACTIVE));

    // Silent source: outstanding cap, underrun, drain, then recovery
    clear_obs();
    ready_mode = 0;
    rsp_en = 1'b0;
    lat = 2;
    step(1'b1, 20);
    repeat (20) step(1'b0, 20);
    check_eq("cap_reqs", 32'(obs_req), 32'(MAX_OUT));
    step(1'b1, 21);
    check_eq("cap_underrun", 32'(underrun), 32'd1);
    repeat (5) step(1'b0, 21);
    step(1'b1, 22);
    check_eq("drain_underrun_cnt", 32'(obs_ur), 32'd2);
    rsp_en = 1'b1;
    run_until_fill(3000, "fill_after_drain");

    // Reset in the middle of a fill
    lat = 3;
    step(1'b1, 30);
    repeat (50) step(1'b0, 30);
    rst = 1'b1;
    step(1'b0, 30);
    rst = 1'b0;
    reset_checks("midrst");
    obs_wr = 0;
    repeat (10) step(1'b0, 30);
    check_eq("late_rsp_wr", 32'(obs_wr), 32'd0);
    step(1'b1, 40);
    check_eq("post_rst_bank", 32'(rd_bank), 32'd1);
    run_until_fill(2000, "fill_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
